// File: rtl/arbitro_mux4_1.sv
// Round-robin arbiter for a shared 4:1 mux. It grants the mux to one of four
// requesters for a bounded burst, hands ownership to the next requester without
// idle cycles, and drives the mux select so that the owner's data reaches the
// output. The mux wires input 3 to sel=00 and input 0 to sel=11, so sel is the
// complement of the owner index.
//
// state | meaning
// IDLE  | no grant asserted; owner/sel keep the last owner
// BUSY  | grant[owner] asserted; counter tracks cycles of the current burst
module arbitro_mux4_1 #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [1:0] owner,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [3:0] r_grant;
    logic [3:0] w_grant_nxt;
    logic [1:0] r_owner;
    logic [1:0] w_owner_nxt;
    logic [1:0] r_sel;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       w_found;
    logic [1:0] w_winner;
    logic       w_release;

    // Priority search starting just after the owner; the owner itself comes last.
    // Scanning from the farthest candidate down lets the nearest one win.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_owner;
        for (int k = 4; k >= 1; k--) begin
            if (req[r_owner + 2'(k)]) begin
                w_found  = 1'b1;
                w_winner = r_owner + 2'(k);
            end
        end
    end

    assign w_release = !req[r_owner] || (r_cnt == CNT_LAST);

    // Next-state, next-grant and burst counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = 4'b0001 << w_winner;
                    w_owner_nxt = w_winner;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_grant_nxt = 4'b0000;
                    w_busy_nxt  = 1'b0;
                end
            end
            BUSY: begin
                if (!w_release) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end else if (w_found) begin
                    // Direct hand-off; the same owner may win again if alone.
                    w_grant_nxt = 4'b0001 << w_winner;
                    w_owner_nxt = w_winner;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 4'b0000;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = 8'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State and output registers; pointer at 3 after reset so requester 0 leads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_grant <= 4'b0000;
            r_owner <= 2'd3;
            r_sel   <= 2'b00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_sel   <= ~w_owner_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule

// File: tb/tb_arbitro_mux4_1.sv
// Testbench for arbitro_mux4_1: directed scenarios plus randomized traffic
// checked against a behavioural round-robin model (one for each hold length).
module tb_arbitro_mux4_1;

    logic       clk;
    logic       rst;
    logic [3:0] req_a;
    logic [3:0] grant_a;
    logic [1:0] sel_a;
    logic [1:0] owner_a;
    logic       busy_a;
    logic [3:0] req_b;
    logic [3:0] grant_b;
    logic [1:0] sel_b;
    logic [1:0] owner_b;
    logic       busy_b;

    int n_cmp;
    int n_bad;

    arbitro_mux4_1 #(.HOLD_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a),
        .grant(grant_a), .sel(sel_a), .owner(owner_a), .busy(busy_a)
    );

    arbitro_mux4_1 #(.HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b),
        .grant(grant_b), .sel(sel_b), .owner(owner_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the mux and how many cycles it has been served.
    logic       ma_busy, mb_busy;
    logic [1:0] ma_owner, mb_owner;
    logic [7:0] ma_served, mb_served;

    function automatic logic [10:0] model_next(input logic [3:0] rq, input logic bsy,
                                               input logic [1:0] own, input logic [7:0] served,
                                               input int hold);
        int  win;
        logic found;
        found = 1'b0;
        win   = own;
        for (int k = 1; k <= 4; k++) begin
            if (!found && rq[(own + k) % 4]) begin
                found = 1'b1;
                win   = (own + k) % 4;
            end
        end
        if (bsy && rq[own] && int'(served) < hold)
            return {1'b1, own, 8'(served + 1)};
        if (found)
            return {1'b1, 2'(win), 8'd1};
        return {1'b0, own, 8'd0};
    endfunction

    function automatic logic [8:0] expect_vec(input logic bsy, input logic [1:0] own);
        logic [3:0] g;
        g = bsy ? (4'b0001 << own) : 4'b0000;
        return {g, 2'(3 - int'(own)), own, bsy};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_busy <= 1'b0; ma_owner <= 2'd3; ma_served <= 8'd0;
            mb_busy <= 1'b0; mb_owner <= 2'd3; mb_served <= 8'd0;
        end else begin
            {ma_busy, ma_owner, ma_served} <= model_next(req_a, ma_busy, ma_owner, ma_served, 4);
            {mb_busy, mb_owner, mb_served} <= model_next(req_b, mb_busy, mb_owner, mb_served, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = 4'b0000; req_b = 4'b0000;
        tick(); tick();
        n_cmp++;
        if ({grant_a, sel_a, owner_a, busy_a} !== {4'b0000, 2'b00, 2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_a: got grant=%b sel=%b owner=%0d busy=%b want 0000 00 3 0",
                     grant_a, sel_a, owner_a, busy_a);
        end
        n_cmp++;
        if ({grant_b, sel_b, owner_b, busy_b} !== {4'b0000, 2'b00, 2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_b: got grant=%b sel=%b owner=%0d busy=%b want 0000 00 3 0",
                     grant_b, sel_b, owner_b, busy_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        req_a = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if ({grant_a, sel_a, owner_a, busy_a} !== {4'b0100, 2'b01, 2'd2, 1'b1}) begin
                n_bad++;
                $display("FAIL single cyc%0d: got grant=%b sel=%b owner=%0d busy=%b want 0100 01 2 1",
                         i, grant_a, sel_a, owner_a, busy_a);
            end
        end
        req_a = 4'b0000;
        tick();
        n_cmp++;
        if ({grant_a, sel_a, owner_a, busy_a} !== {4'b0000, 2'b01, 2'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL single_idle: got grant=%b sel=%b owner=%0d busy=%b want 0000 01 2 0",
                     grant_a, sel_a, owner_a, busy_a);
        end
    endtask

    task automatic test_all_requesting();
        logic [3:0] g;
        logic [1:0] s;
        apply_reset();
        req_a = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick();
            g = 4'b0001 << ((i / 4) % 4);
            s = 2'(3 - ((i / 4) % 4));
            n_cmp++;
            if ({grant_a, sel_a, busy_a} !== {g, s, 1'b1}) begin
                n_bad++;
                $display("FAIL all_req cyc%0d: got grant=%b sel=%b busy=%b want %b %b 1",
                         i, grant_a, sel_a, busy_a, g, s);
            end
        end
    endtask

    task automatic test_early_release();
        apply_reset();
        req_a = 4'b0010;
        tick(); tick();
        req_a = 4'b0000;
        tick();
        n_cmp++;
        if ({grant_a, sel_a, owner_a, busy_a} !== {4'b0000, 2'b10, 2'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL early_idle: got grant=%b sel=%b owner=%0d busy=%b want 0000 10 1 0",
                     grant_a, sel_a, owner_a, busy_a);
        end
        req_a = 4'b1001;
        tick();
        n_cmp++;
        if ({grant_a, sel_a, owner_a, busy_a} !== {4'b1000, 2'b00, 2'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL early_regrant: got grant=%b sel=%b owner=%0d busy=%b want 1000 00 3 1",
                     grant_a, sel_a, owner_a, busy_a);
        end
    endtask

    task automatic test_no_preempt();
        logic [3:0] g;
        apply_reset();
        req_a = 4'b0001;
        tick();
        req_a = 4'b1001;
        for (int i = 1; i < 6; i++) begin
            tick();
            g = (i < 4) ? 4'b0001 : 4'b1000;
            n_cmp++;
            if (grant_a !== g) begin
                n_bad++;
                $display("FAIL no_preempt cyc%0d: got grant=%b want %b", i, grant_a, g);
            end
        end
    endtask

    task automatic test_hold1();
        logic [3:0] g;
        apply_reset();
        req_a = 4'b0000;
        req_b = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            tick();
            g = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            n_cmp++;
            if ({grant_b, busy_b} !== {g, 1'b1}) begin
                n_bad++;
                $display("FAIL hold1 cyc%0d: got grant=%b busy=%b want %b 1", i, grant_b, busy_b, g);
            end
        end
        req_b = 4'b0000;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_a = 4'b1111;
        tick(); tick();
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({grant_a, sel_a, owner_a, busy_a} !== {4'b0000, 2'b00, 2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL async_rst: got grant=%b sel=%b owner=%0d busy=%b want 0000 00 3 0",
                     grant_a, sel_a, owner_a, busy_a);
        end
        req_a = 4'b1000;
        #2;
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({grant_a, sel_a, owner_a, busy_a} !== {4'b1000, 2'b00, 2'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL after_rst: got grant=%b sel=%b owner=%0d busy=%b want 1000 00 3 1",
                     grant_a, sel_a, owner_a, busy_a);
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_a;
        logic [8:0] exp_b;
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) != 0) req_a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_a = 4'b0000;
            req_b = req_a;
            tick();
            exp_a = expect_vec(ma_busy, ma_owner);
            exp_b = expect_vec(mb_busy, mb_owner);
            n_cmp++;
            if ({grant_a, sel_a, owner_a, busy_a} !== exp_a) begin
                n_bad++;
                $display("FAIL rand_a cyc%0d: got grant/sel/owner/busy=%b want %b",
                         i, {grant_a, sel_a, owner_a, busy_a}, exp_a);
            end
            n_cmp++;
            if ({grant_b, sel_b, owner_b, busy_b} !== exp_b) begin
                n_bad++;
                $display("FAIL rand_b cyc%0d: got grant/sel/owner/busy=%b want %b",
                         i, {grant_b, sel_b, owner_b, busy_b}, exp_b);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        test_reset();
        test_single();
        test_all_requesting();
        test_early_release();
        test_no_preempt();
        test_hold1();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
